// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single Register_File write port among N_REQ writeback sources.
// Optional ZERO_REG_FILTER_EN: grants to dest 0 still ack but keep regWrite low.
module regfile_write_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*ADDR_W-1:0]    dest,
    input  logic [N_REQ*DATA_W-1:0]    data,
    output logic [N_REQ-1:0]           ack,
    output logic                       regWrite,
    output logic [ADDR_W-1:0]          regDest,
    output logic [DATA_W-1:0]          DataWrite,
    output logic                       locked
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e              stateQ, stateD;
    idx_t                ownerQ, ownerD;
    idx_t                lastQ, lastD;
    logic [N_REQ-1:0]    ackQ, ackD;
    logic                regWriteQ, regWriteD;
    logic [ADDR_W-1:0]   regDestQ, regDestD;
    logic [DATA_W-1:0]   dataWriteQ, dataWriteD;

    logic [N_REQ-1:0]    eligible;
    logic                rrFound;
    idx_t                rrIdx;
    idx_t                candIdx;
    int unsigned         sum;
    logic                grant;
    idx_t                grantIdx;

    // A source acked this cycle is masked so a still-held req is not granted twice.
    assign eligible = req & ~ackQ;

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        rrFound = 1'b0;
        rrIdx   = '0;
        sum     = 0;
        candIdx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            sum = 32'(lastQ) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            candIdx = idx_t'(sum);
            if (!rrFound && eligible[candIdx]) begin
                rrFound = 1'b1;
                rrIdx   = candIdx;
            end
        end
    end

    always_comb begin
        stateD     = stateQ;
        ownerD     = ownerQ;
        lastD      = lastQ;
        ackD       = '0;
        regWriteD  = 1'b0;
        regDestD   = regDestQ;
        dataWriteD = dataWriteQ;
        grant      = 1'b0;
        grantIdx   = '0;

        unique case (stateQ)
            StIdle: begin
                if (rrFound) begin
                    grant    = 1'b1;
                    grantIdx = rrIdx;
                end
            end
            StLocked: begin
                if (eligible[ownerQ]) begin
                    grant    = 1'b1;
                    grantIdx = ownerQ;
                end else if (!req[ownerQ]) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        if (grant) begin
            ackD[grantIdx] = 1'b1;
            regDestD       = dest[grantIdx*ADDR_W +: ADDR_W];
            dataWriteD     = data[grantIdx*DATA_W +: DATA_W];
`ifdef ZERO_REG_FILTER_EN
            regWriteD      = (dest[grantIdx*ADDR_W +: ADDR_W] != '0);
`else
            regWriteD      = 1'b1;
`endif
            lastD          = grantIdx;
            if (lock[grantIdx]) begin
                stateD = StLocked;
                ownerD = grantIdx;
            end else begin
                stateD = StIdle;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateQ     <= StIdle;
            ownerQ     <= '0;
            lastQ      <= idx_t'(N_REQ - 1);
            ackQ       <= '0;
            regWriteQ  <= 1'b0;
            regDestQ   <= '0;
            dataWriteQ <= '0;
        end else begin
            stateQ     <= stateD;
            ownerQ     <= ownerD;
            lastQ      <= lastD;
            ackQ       <= ackD;
            regWriteQ  <= regWriteD;
            regDestQ   <= regDestD;
            dataWriteQ <= dataWriteD;
        end
    end

    assign ack       = ackQ;
    assign regWrite  = regWriteQ;
    assign regDest   = regDestQ;
    assign DataWrite = dataWriteQ;
    assign locked    = (stateQ == StLocked);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [8:0]  dest;
    logic [47:0] data;
    logic [2:0]  ack;
    logic        regWrite;
    logic [2:0]  regDest;
    logic [15:0] DataWrite;
    logic        locked;

    int total = 0;
    int bad   = 0;

    logic [15:0] rf [8] = '{default: 16'd0};

    regfile_write_arbiter #(
        .N_REQ (3),
        .DATA_W(16),
        .ADDR_W(3)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .req      (req),
        .lock     (lock),
        .dest     (dest),
        .data     (data),
        .ack      (ack),
        .regWrite (regWrite),
        .regDest  (regDest),
        .DataWrite(DataWrite),
        .locked   (locked)
    );

    always #5 CLK = ~CLK;

    // Register_File model: captures on the edge after the write is presented, ignores reg 0.
    always @(posedge CLK) begin
        if (regWrite && regDest != 3'd0) begin
            rf[regDest] <= DataWrite;
        end
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  lock;
        logic [8:0]  dest;
        logic [47:0] data;
        logic [2:0]  ack;
        logic        rw;
        logic [2:0]  rd;
        logic [15:0] dw;
        logic        lk;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOut(input string name, input logic [2:0] eAck, input logic eRw,
                            input logic [2:0] eRd, input logic [15:0] eDw, input logic eLk);
        check({name, " ack"}, 32'(ack), 32'(eAck));
        check({name, " regWrite"}, 32'(regWrite), 32'(eRw));
        check({name, " regDest"}, 32'(regDest), 32'(eRd));
        check({name, " DataWrite"}, 32'(DataWrite), 32'(eDw));
        check({name, " locked"}, 32'(locked), 32'(eLk));
    endtask

    initial begin
        logic expZeroRw;
`ifdef ZERO_REG_FILTER_EN
        expZeroRw = 1'b0;
`else
        expZeroRw = 1'b1;
`endif

        // Fairness rows start from a fresh reset (pointer at source 2), then a single held source.
        vecs[0] = '{3'b111, 3'b000, {3'd4, 3'd3, 3'd2}, {16'd2, 16'd54315, 16'd45632},
                    3'b001, 1'b1, 3'd2, 16'd45632, 1'b0};
        vecs[1] = '{3'b111, 3'b000, {3'd4, 3'd3, 3'd2}, {16'd2, 16'd54315, 16'd45632},
                    3'b010, 1'b1, 3'd3, 16'd54315, 1'b0};
        vecs[2] = '{3'b111, 3'b000, {3'd4, 3'd3, 3'd2}, {16'd2, 16'd54315, 16'd45632},
                    3'b100, 1'b1, 3'd4, 16'd2, 1'b0};
        vecs[3] = '{3'b111, 3'b000, {3'd4, 3'd3, 3'd2}, {16'd2, 16'd54315, 16'd45632},
                    3'b001, 1'b1, 3'd2, 16'd45632, 1'b0};
        vecs[4] = '{3'b000, 3'b000, {3'd4, 3'd3, 3'd2}, {16'd2, 16'd54315, 16'd45632},
                    3'b000, 1'b0, 3'd2, 16'd45632, 1'b0};
        vecs[5] = '{3'b010, 3'b000, {3'd4, 3'd5, 3'd2}, {16'd2, 16'd34556, 16'd45632},
                    3'b010, 1'b1, 3'd5, 16'd34556, 1'b0};
        vecs[6] = '{3'b010, 3'b000, {3'd4, 3'd5, 3'd2}, {16'd2, 16'd34556, 16'd45632},
                    3'b000, 1'b0, 3'd5, 16'd34556, 1'b0};
        vecs[7] = '{3'b010, 3'b000, {3'd4, 3'd5, 3'd2}, {16'd2, 16'd34556, 16'd45632},
                    3'b010, 1'b1, 3'd5, 16'd34556, 1'b0};
        vecs[8] = '{3'b010, 3'b000, {3'd4, 3'd5, 3'd2}, {16'd2, 16'd34556, 16'd45632},
                    3'b000, 1'b0, 3'd5, 16'd34556, 1'b0};
        vecs[9] = '{3'b000, 3'b000, {3'd4, 3'd5, 3'd2}, {16'd2, 16'd34556, 16'd45632},
                    3'b000, 1'b0, 3'd5, 16'd34556, 1'b0};

        // Reset held with all sources requesting.
        RST_N = 1'b0;
        req   = 3'b111;
        lock  = 3'b000;
        dest  = {3'd0, 3'd0, 3'd1};
        data  = {16'd0, 16'd0, 16'd3401};
        repeat (3) tick();
        checkOut("reset", 3'b000, 1'b0, 3'd0, 16'd0, 1'b0);
        #2 RST_N = 1'b1;
        tick();
        checkOut("first grant", 3'b001, 1'b1, 3'd1, 16'd3401, 1'b0);
        req = 3'b000;
        tick();
        checkOut("idle hold", 3'b000, 1'b0, 3'd1, 16'd3401, 1'b0);
        check("rf r1", 32'(rf[1]), 32'd3401);

        // Fresh reset so the table starts from the reset pointer.
        #2 RST_N = 1'b0;
        #2 RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req  = vecs[i].req;
            lock = vecs[i].lock;
            dest = vecs[i].dest;
            data = vecs[i].data;
            tick();
            checkOut($sformatf("vec%0d", i), vecs[i].ack, vecs[i].rw, vecs[i].rd, vecs[i].dw,
                     vecs[i].lk);
        end
        check("rf sp single", 32'(rf[5]), 32'd34556);

        // Lock: source 2 writes sp then ra atomically while source 0 keeps requesting.
        req  = 3'b101;
        lock = 3'b100;
        dest = {3'd5, 3'd0, 3'd1};
        data = {16'd100, 16'd0, 16'd777};
        tick();
        checkOut("lock grant1", 3'b100, 1'b1, 3'd5, 16'd100, 1'b1);
        lock = 3'b000;
        dest = {3'd6, 3'd0, 3'd1};
        data = {16'd200, 16'd0, 16'd777};
        tick();
        checkOut("lock stall", 3'b000, 1'b0, 3'd5, 16'd100, 1'b1);
        tick();
        checkOut("lock grant2", 3'b100, 1'b1, 3'd6, 16'd200, 1'b0);
        req = 3'b001;
        tick();
        checkOut("after lock src0", 3'b001, 1'b1, 3'd1, 16'd777, 1'b0);
        check("rf sp", 32'(rf[5]), 32'd100);
        check("rf ra", 32'(rf[6]), 32'd200);
        req = 3'b000;
        tick();

        // Reset while locked clears outputs without a clock edge.
        req  = 3'b100;
        lock = 3'b100;
        dest = {3'd5, 3'd0, 3'd1};
        data = {16'd55, 16'd0, 16'd3401};
        tick();
        checkOut("pre-reset lock", 3'b100, 1'b1, 3'd5, 16'd55, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        checkOut("async reset", 3'b000, 1'b0, 3'd0, 16'd0, 1'b0);
        req  = 3'b111;
        lock = 3'b000;
        dest = {3'd4, 3'd3, 3'd1};
        #2 RST_N = 1'b1;
        tick();
        checkOut("post-reset", 3'b001, 1'b1, 3'd1, 16'd3401, 1'b0);
        req = 3'b000;
        tick();

        // Write to register 0.
        req  = 3'b001;
        dest = {3'd4, 3'd3, 3'd0};
        data = {16'd0, 16'd0, 16'd300};
        tick();
        checkOut("zero dest", 3'b001, expZeroRw, 3'd0, 16'd300, 1'b0);
        req = 3'b000;
        tick();
        checkOut("zero after", 3'b000, 1'b0, 3'd0, 16'd300, 1'b0);
        check("rf wr", 32'(rf[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
